pc_gen: RTL



---
 rtl/pc_gen_pkg.sv | 14 +
 rtl/pc_ras.sv | 57 +++++
 rtl/pc_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: FSM state encoding,
// instruction size and branch-offset shift.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int unsigned INSN_SIZE = 4;
  localparam int unsigned OFF_SHIFT = 2;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer addressed by a top pointer plus an
// occupancy count. Pushing when full overwrites the oldest entry. Popping
// when empty is a no-op. Push and pop together replace the top entry.
// DEPTH must be a power of two, at least 2.
module pc_ras #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  top_inc;
  logic [CNT_W-1:0]  count;

  assign top_inc  = top + 1'b1;
  assign top_data = mem[top];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

  // Pointer and count: the pointer wraps freely, so a full push silently
  // drops the oldest entry while the count saturates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      top   <= '0;
      count <= '0;
    end else if (push && pop) begin
      top   <= top;
      count <= count;
    end else if (push) begin
      top <= top_inc;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      top   <= top - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Entry storage; a push paired with a pop rewrites the current top.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[pop ? top : top_inc] <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with BOOT/RUN/HALT control, PC-relative and
// indirect branches, and an optional return-address stack compiled in by
// defining PC_RAS_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       COND_W    = 19,
  parameter int unsigned       UNCOND_W  = 26,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                br_taken_i,
  input  logic                uncond_br_i,
  input  logic [COND_W-1:0]   cond_off_i,
  input  logic [UNCOND_W-1:0] uncond_off_i,
  input  logic                call_i,
  input  logic                ret_i,
  input  logic [ADDR_W-1:0]   reg_target_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  input  logic                halt_i,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [ADDR_W-1:0]   pc_plus4_o,
  output logic                valid_o,
  output logic                halted_o,
  output logic                ras_empty_o,
  output logic                ras_full_o
);

  pc_state_e         state;
  logic [ADDR_W-1:0] cond_ext;
  logic [ADDR_W-1:0] uncond_ext;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] ret_target;
  logic [ADDR_W-1:0] seq_target;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              advance;
  logic              push;
  logic              pop;

  assign pc_plus4_o = pc_o + ADDR_W'(INSN_SIZE);

  assign cond_ext   = ADDR_W'($signed(cond_off_i));
  assign uncond_ext = ADDR_W'($signed(uncond_off_i));
  assign br_target  = pc_o + ((uncond_br_i ? uncond_ext : cond_ext) << OFF_SHIFT);
  assign ret_target = ras_empty ? reg_target_i : ras_top;

  // A RUN cycle that actually moves the PC along the program.
  assign advance = (state == ST_RUN) && !redirect_i && !halt_i && !stall_i;
  assign push    = advance && call_i && br_taken_i && uncond_br_i;
  assign pop     = advance && ret_i;

`ifdef PC_RAS_EN
  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus4_o),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  logic unused_ras;
  assign unused_ras = call_i ^ push ^ pop;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;

  // Program-flow target for an unstalled RUN cycle: return, branch, or next.
  always_comb begin
    seq_target = pc_plus4_o;
    if (ret_i) begin
      seq_target = ret_target;
    end else if (br_taken_i) begin
      seq_target = br_target;
    end
  end

  // Control FSM with registered PC, valid and halted outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_BOOT;
      pc_o     <= RESET_VEC;
      valid_o  <= 1'b0;
      halted_o <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state   <= ST_RUN;
          pc_o    <= RESET_VEC;
          valid_o <= 1'b1;
        end
        ST_RUN: begin
          if (redirect_i) begin
            pc_o <= redirect_pc_i;
          end else if (halt_i) begin
            state    <= ST_HALT;
            valid_o  <= 1'b0;
            halted_o <= 1'b1;
          end else if (!stall_i) begin
            pc_o <= seq_target;
          end
        end
        ST_HALT: begin
          if (redirect_i) begin
            state    <= ST_RUN;
            pc_o     <= redirect_pc_i;
            valid_o  <= 1'b1;
            halted_o <= 1'b0;
          end
        end
        default: begin
          state    <= ST_BOOT;
          pc_o     <= RESET_VEC;
          valid_o  <= 1'b0;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
